// File: rtl/cfg_chain_if.sv
// cfg_chain_if
//   Host-side stream bundle for cfg_chain_ctrl.
//   s_*  : host -> controller configuration words (valid/ready)
//   m_*  : controller -> host readback words (valid/ready)
//   master modport is the host; slave modport is the controller.
interface cfg_chain_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );
endinterface

// File: rtl/cfg_chain_ctrl.sv
// cfg_chain_ctrl
//   Drives a daisy-chained LE configuration shift register.
//   LOAD     : host words are serialized LSB-first into cfg_data with cfg_en high.
//   READBACK : cfg_ret is recirculated into cfg_data while being packed into
//              words for the host, so the chain ends up unchanged.
// Ports:
//   clk, nrst       clock, asynchronous active-low reset
//   start, mode     begin operation (mode 0 = LOAD, 1 = READBACK), sampled in IDLE
//   abort           return to IDLE next cycle from any state
//   host            cfg_chain_if.slave: s_data/s_valid/s_ready, m_data/m_valid/m_ready
//   cfg_en          chain shift enable
//   cfg_data        serial bit into the first LE
//   cfg_ret         serial bit out of the last LE
//   busy, done      not-IDLE flag, one-cycle completion pulse
module cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 80,
  parameter int WORD_W    = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  cfg_chain_if.slave  host,
  output logic        cfg_en,
  output logic        cfg_data,
  input  logic        cfg_ret,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  ALL_BITS = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_WAIT, LOAD_SHIFT, RB_SHIFT, RB_OUT, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [WORD_W-1:0]  ld_buf_q, ld_buf_d;
  logic [WORD_W-1:0]  rb_buf_q, rb_buf_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic               cfg_en_q, cfg_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // A word ends either when it is full or when the chain is exhausted
  // (partial last word).
  logic word_last;
  logic chain_last;
  assign chain_last = (bit_cnt_q == LAST_BIT);
  assign word_last  = (wcnt_q == WLAST) || chain_last;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    wcnt_d    = wcnt_q;
    ld_buf_d  = ld_buf_q;
    rb_buf_d  = rb_buf_q;

    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      wcnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bit_cnt_d = '0;
            wcnt_d    = '0;
            rb_buf_d  = '0;
            state_d   = mode ? RB_SHIFT : LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (host.s_valid && s_ready_q) begin
            ld_buf_d = host.s_data;
            wcnt_d   = '0;
            state_d  = LOAD_SHIFT;
          end
        end
        LOAD_SHIFT: begin
          ld_buf_d  = ld_buf_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          wcnt_d    = wcnt_q + 1'b1;
          if (word_last) state_d = chain_last ? FINISH : LOAD_WAIT;
        end
        RB_SHIFT: begin
          // Bit k of the word is the k-th bit to emerge, so a partial
          // last word lands in the low positions with zeros above.
          rb_buf_d[wcnt_q] = cfg_ret;
          bit_cnt_d        = bit_cnt_q + 1'b1;
          wcnt_d           = wcnt_q + 1'b1;
          if (word_last) state_d = RB_OUT;
        end
        RB_OUT: begin
          if (m_valid_q && host.m_ready) begin
            if (bit_cnt_q == ALL_BITS) begin
              state_d = FINISH;
            end else begin
              rb_buf_d = '0;
              wcnt_d   = '0;
              state_d  = RB_SHIFT;
            end
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered versions of the next-state decode.
    s_ready_d = (state_d == LOAD_WAIT);
    m_valid_d = (state_d == RB_OUT);
    cfg_en_d  = (state_d == LOAD_SHIFT) || (state_d == RB_SHIFT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      wcnt_q    <= '0;
      ld_buf_q  <= '0;
      rb_buf_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      cfg_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wcnt_q    <= wcnt_d;
      ld_buf_q  <= ld_buf_d;
      rb_buf_q  <= rb_buf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      cfg_en_q  <= cfg_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // cfg_data cannot be registered during readback: the chain must take in
  // the very bit it is presenting on cfg_ret at the same edge, otherwise the
  // recirculation would be off by one and corrupt the contents.
  assign cfg_data = (state_q == RB_SHIFT) ? cfg_ret
                                          : ((state_q == LOAD_SHIFT) && ld_buf_q[0]);

  assign cfg_en       = cfg_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign host.s_ready = s_ready_q;
  assign host.m_valid = m_valid_q;
  assign host.m_data  = rb_buf_q;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// tb_cfg_chain_ctrl
//   Directed bench for cfg_chain_ctrl with a 20-bit shift-register chain
//   model (bit 0 takes cfg_data, bit 19 drives cfg_ret).
module tb_cfg_chain_ctrl;
  localparam int CL = 20;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic abort = 1'b0;
  logic cfg_en, cfg_data, cfg_ret, busy, done;

  always #5 clk = ~clk;

  cfg_chain_if #(.WORD_W(WW)) bus ();

  cfg_chain_ctrl #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .mode     (mode),
    .abort    (abort),
    .host     (bus.slave),
    .cfg_en   (cfg_en),
    .cfg_data (cfg_data),
    .cfg_ret  (cfg_ret),
    .busy     (busy),
    .done     (done)
  );

  // Chain model
  logic [CL-1:0] chain = '0;
  assign cfg_ret = chain[CL-1];
  always @(posedge clk) if (cfg_en) chain <= {chain[CL-2:0], cfg_data};

  // Activity monitor
  int          en_cnt   = 0;
  int          done_cnt = 0;
  logic [63:0] seq      = '0;
  always @(negedge clk) begin
    if (cfg_en) begin
      if (en_cnt < 64) seq[en_cnt] = cfg_data;
      en_cnt++;
    end
    if (done) done_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [CL-1:0] snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic clr_stats();
    en_cnt   = 0;
    done_cnt = 0;
    seq      = '0;
  endtask

  task automatic go(input logic m);
    @(posedge clk); #1;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input string tag);
    logic seen;
    if (gap > 0) begin
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk); seen = bus.s_ready;
      end
      check({tag, "_ready"}, 32'(seen), 32'd1);
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        check({tag, "_gap_en"}, 32'(cfg_en), 32'd0);
      end
      @(posedge clk); #1;
    end
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); seen = bus.s_ready;
      @(posedge clk); #1;
    end
    check({tag, "_accept"}, 32'(seen), 32'd1);
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic recv_word(input logic [7:0] exp, input int stall, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); seen = bus.m_valid;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_data"}, 32'(bus.m_data), 32'(exp));
    check({tag, "_en_low"}, 32'(cfg_en), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.m_data !== exp || cfg_en !== 1'b0 || bus.m_valid !== 1'b1)
        check({tag, "_stall"}, {23'd0, cfg_en, bus.m_data}, {24'd0, exp});
    end
    if (stall > 0)
      check({tag, "_stall_end"}, {22'd0, bus.m_valid, cfg_en, bus.m_data}, {22'd0, 2'b10, exp});
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input logic chk_seq, input logic [CL-1:0] exp_seq);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); seen = !busy;
    end
    check({tag, "_idle"}, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, "_en_cycles"}, 32'(en_cnt), 32'(CL));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    if (chk_seq) check({tag, "_bits"}, 32'(seq[CL-1:0]), 32'(exp_seq));
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    #2 nrst = 1'b0;
    #10;
    check("rst_outs", {25'd0, busy, done, cfg_en, cfg_data, bus.s_ready, bus.m_valid, 1'b0},
          32'd0);
    check("rst_mdata", 32'(bus.m_data), 32'd0);
    @(negedge clk); nrst = 1'b1;

    // 1: LOAD A5,3C,0F
    clr_stats();
    go(1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    send_word(8'hA5, 0, "t1_w0");
    send_word(8'h3C, 0, "t1_w1");
    send_word(8'h0F, 0, "t1_w2");
    wait_idle("t1", 1'b1, 20'hF3CA5);
    snap = chain;

    // 2: READBACK
    clr_stats();
    go(1'b1);
    recv_word(8'hA5, 0, "t2_w0");
    recv_word(8'h3C, 0, "t2_w1");
    recv_word(8'h0F, 0, "t2_w2");
    wait_idle("t2", 1'b0, '0);
    check("t2_chain_kept", 32'(chain), 32'(snap));

    // 3: gapped LOAD into a cleared chain; upper nibble of last word discarded
    @(negedge clk); chain = '0;
    clr_stats();
    go(1'b0);
    send_word(8'hA5, 0, "t3_w0");
    send_word(8'h3C, 5, "t3_w1");
    send_word(8'hAF, 5, "t3_w2");
    wait_idle("t3", 1'b1, 20'hF3CA5);
    check("t3_chain", 32'(chain), 32'(snap));

    // 4: READBACK with host stall on word 2
    clr_stats();
    go(1'b1);
    recv_word(8'hA5, 0, "t4_w0");
    recv_word(8'h3C, 10, "t4_w1");
    recv_word(8'h0F, 0, "t4_w2");
    wait_idle("t4", 1'b0, '0);
    check("t4_chain_kept", 32'(chain), 32'(snap));

    // 5: abort in the middle of word 2's shift
    clr_stats();
    go(1'b0);
    send_word(8'hA5, 0, "t5_w0");
    send_word(8'h3C, 0, "t5_w1");
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_abort_outs", {29'd0, busy, cfg_en, bus.s_ready}, 32'd0);
    repeat (5) @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_en_cycles", 32'(en_cnt), 32'd11);
    check("t5_still_idle", 32'(busy), 32'd0);
    clr_stats();
    go(1'b0);
    send_word(8'h5A, 0, "t5_w0b");
    send_word(8'hC3, 0, "t5_w1b");
    send_word(8'h06, 0, "t5_w2b");
    wait_idle("t5_reload", 1'b1, 20'h6C35A);
    clr_stats();
    go(1'b1);
    recv_word(8'h5A, 0, "t5_rb0");
    recv_word(8'hC3, 0, "t5_rb1");
    recv_word(8'h06, 0, "t5_rb2");
    wait_idle("t5_rb", 1'b0, '0);

    // 6: asynchronous reset during RB_OUT
    go(1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk); seen = bus.m_valid;
      end
      check("t6_rb_out", 32'(seen), 32'd1);
    end
    nrst = 1'b0;
    #1;
    check("t6_rst_outs", {26'd0, busy, done, cfg_en, cfg_data, bus.s_ready, bus.m_valid},
          32'd0);
    check("t6_rst_mdata", 32'(bus.m_data), 32'd0);
    #2 nrst = 1'b1;

    // start while busy is ignored
    go(1'b0);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    check("t6_busy_start", {29'd0, busy, bus.s_ready, cfg_en}, 32'b110);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_abort_idle", 32'(busy), 32'd0);

    // start together with abort in IDLE
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("t6_start_abort", {29'd0, busy, bus.s_ready, cfg_en}, 32'd0);
    @(posedge clk); #1;
    check("t6_start_abort2", {29'd0, busy, bus.s_ready, cfg_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cfg_chain_ctrl.md
Name: cfg_chain_ctrl

Overview:
- Configuration controller for a serial chain of LE configuration registers; drives the chain's shift-enable and serial data input.
- Accepts configuration words from a host over a valid/ready stream and serializes them into the chain (LOAD).
- Also performs a non-destructive READBACK: the chain output is recirculated into its input while being packed into words for the host.
- Sits between the host/programming interface and the fabric's daisy-chained LE config ports.

Parameters:
CHAIN_LEN, 80, total config bits in the chain (4 LEs x 20 bits); must be >= 1
WORD_W, 8, host word width in bits; must be >= 1

Ports:
clk  in  1  system/config clock; one clock only
nrst  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
mode  in  1  0 = LOAD, 1 = READBACK; sampled with start
abort  in  1  return to IDLE next cycle from any state
s_data  in  WORD_W  host config word
s_valid  in  1  s_data valid
s_ready  out  1  controller accepts s_data this cycle
m_data  out  WORD_W  readback word
m_valid  out  1  m_data valid
m_ready  in  1  host accepts m_data
cfg_en  out  1  chain shift enable; drives LE en and config_en
cfg_data  out  1  serial bit into the first LE's config_data_in
cfg_ret  in  1  config_data_out of the last LE
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Clock and reset: clk is the only clock. nrst is asynchronous, active low.
- Reset values: state = IDLE; all outputs 0; bit counter = 0; word buffers = 0.
- States:
  - IDLE: start=1 -> LOAD_WAIT if mode=0, RB_SHIFT if mode=1. busy rises the cycle after start.
  - LOAD_WAIT: s_ready=1. On s_valid&&s_ready, capture s_data -> LOAD_SHIFT on the next cycle.
  - LOAD_SHIFT: cfg_en=1 every cycle. cfg_data = buffer LSB. Buffer shifts right one bit per cycle.
    - Stays for n = min(WORD_W, bits remaining) cycles.
    - Then goes to LOAD_WAIT, or to FINISH if CHAIN_LEN bits have been sent.
    - s_ready=0 here, so there is exactly one bubble cycle per word.
  - RB_SHIFT: cfg_en=1. cfg_data = cfg_ret (recirculate). cfg_ret is shifted into the readback buffer.
    - After n = min(WORD_W, remaining) bits -> RB_OUT.
  - RB_OUT: cfg_en=0. m_valid=1, m_data = packed word, held stable until m_ready.
    - On m_valid&&m_ready -> RB_SHIFT, or FINISH if CHAIN_LEN bits are done.
  - FINISH: done=1 for one cycle, cfg_en=0 -> IDLE. busy is still 1 in FINISH.
- Bit order:
  - Words are serialized LSB-first.
  - The first bit shifted ends deepest in the chain (MSB of the last LE).
  - Readback bit k of a word is the k-th bit emerging from cfg_ret.
- Partial last word (CHAIN_LEN mod WORD_W = r != 0):
  - LOAD uses the low r bits; the upper bits are discarded.
  - READBACK returns r bits in the low positions with the upper bits 0.
- Totals: exactly CHAIN_LEN cfg_en cycles per completed operation; ceil(CHAIN_LEN/WORD_W) words transferred.
- READBACK leaves chain contents unchanged after completion.
- cfg_en is never high in IDLE, LOAD_WAIT, RB_OUT or FINISH. The host can stall indefinitely without the chain moving.
- Inputs ignored while busy: start and mode. s_valid when s_ready=0 is not accepted; the host must hold its word.
- abort:
  - Takes priority over every other transition.
  - Next cycle: state IDLE, cfg_en=0, s_ready=0, m_valid=0, counter cleared, no done pulse.
  - Chain contents after abort are undefined (partial shift).
- Simultaneous start and abort in IDLE: abort wins and the controller stays IDLE.
- nrst mid-operation: immediate return to reset values, chain shifting stops the same instant.
- Counter width: $clog2(CHAIN_LEN+1).

Test Plan:
1. CHAIN_LEN=20, WORD_W=8, LOAD with words 0xA5, 0x3C, 0x0F -> cfg_en high exactly 20 cycles. cfg_data sequence = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. One done pulse. Then IDLE.
2. After test 1, READBACK against a 20-bit shift-register chain model -> m_data = 0xA5, 0x3C, 0x0F (upper nibble 0). Chain contents identical to before readback.
3. LOAD with s_valid gapped by 5 idle cycles between words -> cfg_en low during gaps. Total cfg_en cycles still 20. Same final chain contents.
4. READBACK with m_ready held low 10 cycles on word 2 -> m_data stable, cfg_en=0 throughout the stall. Correct words after release.
5. abort asserted mid-LOAD_SHIFT of word 2 -> next cycle IDLE, busy=0, cfg_en=0, done never pulses. A new LOAD then completes normally.
6. nrst pulsed low during RB_OUT -> all outputs 0 asynchronously. start while busy or with abort in IDLE -> ignored.
